// File: rtl/shift_rows_stream.sv
`default_nettype none
// shift_rows_stream: byte-serial AES ShiftRows / InvShiftRows over a ping-pong state buffer
// with valid/ready on both sides.  Revision 1.0
module shift_rows_stream #(
  parameter int DATA_W = 8,
  parameter int NB     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode_inv,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] inbyte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] outbyte,
  output logic              out_last,
  output logic              ready
);

  localparam int N  = 4 * NB;
  localparam int AW = $clog2(N);
  // Column arithmetic width: holds c + NB - s without overflow for every legal NB.
  localparam int CW = $clog2(NB) + 1;
  localparam logic [AW-1:0] LAST   = AW'(N - 1);
  localparam logic [CW:0]   NB_VAL = (CW + 1)'(NB);

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("shift_rows_stream: NB must be 4, 6 or 8");
    end
  endgenerate

  logic [DATA_W-1:0] mem [2][N];
  logic [1:0]        full;
  logic [1:0]        mode;
  logic              wbank;
  logic              rbank;
  logic [AW-1:0]     wcnt;
  logic [AW-1:0]     rcnt;
  logic              held;
  logic              wr_en;
  logic              rd_en;

  assign in_ready  = !full[wbank];
  assign out_valid = full[rbank];
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;

  // Output position rcnt = 4*c + r reads source column (c +/- s(r)) mod NB of the same row.
  logic [1:0]    row;
  logic [CW-1:0] col;
  logic [CW-1:0] shamt;
  logic [CW:0]   sum;
  logic [CW-1:0] src_col;
  logic [AW-1:0] src_addr;

  always_comb begin
    row   = rcnt[1:0];
    col   = CW'(rcnt >> 2);
    shamt = (NB == 8 && row >= 2'd2) ? CW'(row) + CW'(1) : CW'(row);
    if (mode[rbank]) begin
      sum = {1'b0, col} + NB_VAL - {1'b0, shamt};
    end else begin
      sum = {1'b0, col} + {1'b0, shamt};
    end
    if (sum >= NB_VAL) begin
      sum = sum - NB_VAL;
    end
    src_col  = sum[CW-1:0];
    src_addr = AW'({src_col, row});
  end

  assign outbyte  = mem[rbank][src_addr];
  assign out_last = out_valid && (rcnt == LAST);
  // held suppresses a second pulse while the first byte of a block waits on out_ready.
  assign ready    = out_valid && (rcnt == '0) && !held;

  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt  <= '0;
      rcnt  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      full  <= '0;
      mode  <= '0;
      held  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else begin
      if (wr_en) begin
        mem[wbank][wcnt] <= inbyte;
        if (wcnt == '0) begin
          mode[wbank] <= mode_inv;
        end
        if (wcnt == LAST) begin
          full[wbank] <= 1'b1;
          wbank       <= !wbank;
          wcnt        <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
      if (rd_en) begin
        held <= 1'b0;
        if (rcnt == LAST) begin
          full[rbank] <= 1'b0;
          rbank       <= !rbank;
          rcnt        <= '0;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end else if (ready) begin
        held <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_stream.sv
`default_nettype none
// tb_shift_rows_stream: directed and random stimulus for shift_rows_stream, checked every cycle
// against a row/column ShiftRows model and a few literal AES vectors.
module tb_shift_rows_stream;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, mode_inv, in_valid, out_ready;
  logic [7:0] inbyte;
  logic       in_ready, out_valid, out_last, ready;
  logic [7:0] outbyte;

  logic       mode_inv_8, in_valid_8, out_ready_8;
  logic [7:0] inbyte_8;
  logic       in_ready_8, out_valid_8, out_last_8, ready_8;
  logic [7:0] outbyte_8;

  shift_rows_stream #(.DATA_W(8), .NB(4)) dut4 (
    .clock(clock), .reset(reset), .mode_inv(mode_inv), .in_valid(in_valid),
    .in_ready(in_ready), .inbyte(inbyte), .out_valid(out_valid), .out_ready(out_ready),
    .outbyte(outbyte), .out_last(out_last), .ready(ready)
  );

  shift_rows_stream #(.DATA_W(8), .NB(8)) dut8 (
    .clock(clock), .reset(reset), .mode_inv(mode_inv_8), .in_valid(in_valid_8),
    .in_ready(in_ready_8), .inbyte(inbyte_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
    .outbyte(outbyte_8), .out_last(out_last_8), .ready(ready_8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: out[r][c] = in[r][(c +/- s(r)) mod NB], byte k = 4*c + r.
  typedef logic [7:0] blk_t [32];

  function automatic int shamt(input int r, input int nb);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction

  function automatic void xform(input blk_t src, input bit inv, input int nb, output blk_t dst);
    dst = '{default: 8'h00};
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        int sc;
        sc = inv ? (c - shamt(r, nb) + nb) % nb : (c + shamt(r, nb)) % nb;
        dst[4*c + r] = src[4*sc + r];
      end
    end
  endfunction

  logic [7:0] A_IN  [16] = '{8'hd4,8'hbf,8'h5d,8'h30,8'he0,8'hb4,8'h52,8'hae,
                             8'hb8,8'h41,8'h11,8'hf1,8'h1e,8'h27,8'h98,8'he5};
  logic [7:0] A_OUT [16] = '{8'hd4,8'h27,8'h11,8'hae,8'he0,8'hbf,8'h98,8'hf1,
                             8'hb8,8'hb4,8'h5d,8'he5,8'h1e,8'h41,8'h52,8'h30};
  logic [7:0] B_IN  [16] = '{8'h49,8'hdb,8'h87,8'h3b,8'h45,8'h39,8'h53,8'h89,
                             8'h7f,8'h02,8'hd2,8'hf1,8'h77,8'hde,8'h96,8'h1a};
  logic [7:0] B_OUT [16] = '{8'h49,8'h39,8'hd2,8'h1a,8'h45,8'h02,8'h96,8'h3b,
                             8'h7f,8'hde,8'h87,8'h89,8'h77,8'hdb,8'h53,8'hf1};
  logic [7:0] COL0_8 [4] = '{8'h00,8'h05,8'h0e,8'h13};

  // Scoreboard for the NB=4 instance.
  typedef struct { logic [7:0] b; bit last; bit first; } item_t;
  item_t      expq[$];
  logic [7:0] part[$];
  bit         part_inv;
  bit         head_shown;
  bit         prev_ov;
  blk_t       m_src, m_dst;
  int         sz;
  logic [7:0] cap4[$];
  int         neg = 0;
  int         acc_cnt = 0, tx_cnt = 0;
  int         last_acc_neg = 0, first_rise_neg = -1, first_tx_neg = -1, last_tx_neg = 0;
  logic [7:0] last_byte, ready_byte;

  always @(negedge clock) begin
    neg++;
    if (reset) begin
      expq.delete();
      part.delete();
      head_shown = 1'b0;
      prev_ov    = 1'b0;
    end else begin
      sz = expq.size();
      check("in_ready", in_ready, sz <= 16);
      check("out_valid", out_valid, sz != 0);
      if (out_valid && sz != 0) begin
        check("outbyte", outbyte, expq[0].b);
        check("out_last", out_last, expq[0].last);
        check("ready", ready, expq[0].first && !head_shown);
        if (!prev_ov) first_rise_neg = neg;
        if (out_ready) begin
          if (first_tx_neg < 0) first_tx_neg = neg;
          last_tx_neg = neg;
          if (out_last) last_byte = outbyte;
          if (ready) ready_byte = outbyte;
          cap4.push_back(outbyte);
          tx_cnt++;
          void'(expq.pop_front());
          head_shown = 1'b0;
        end else begin
          head_shown = 1'b1;
        end
      end else begin
        check("ready_idle", ready, 0);
        check("out_last_idle", out_last, 0);
      end
      prev_ov = out_valid;
      if (in_valid && in_ready) begin
        if (part.size() == 0) part_inv = mode_inv;
        part.push_back(inbyte);
        acc_cnt++;
        last_acc_neg = neg;
        if (part.size() == 16) begin
          m_src = '{default: 8'h00};
          for (int i = 0; i < 16; i++) m_src[i] = part[i];
          xform(m_src, part_inv, 4, m_dst);
          for (int i = 0; i < 16; i++) expq.push_back('{m_dst[i], i == 15, i == 0});
          part.delete();
        end
      end
    end
  end

  logic [7:0] cap8[$];
  bit         last8[$];
  always @(negedge clock) begin
    if (!reset && out_valid_8 && out_ready_8) begin
      cap8.push_back(outbyte_8);
      last8.push_back(out_last_8);
    end
  end

  bit rand_bp = 1'b0;
  always @(posedge clock) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  int stalls = 0;

  task automatic send_byte(input logic [7:0] b, input bit m);
    int w;
    bit acc;
    w   = 0;
    acc = 1'b0;
    inbyte   = b;
    mode_inv = m;
    in_valid = 1'b1;
    do begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      w++;
    end while (!acc && w < 2000);
    if (!acc) check("send_timeout", acc, 1);
    stalls += w - 1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (expq.size() != 0 && w < 3000) begin
      @(posedge clock);
      w++;
    end
    #1;
    check("drain_timeout", expq.size(), 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  blk_t pin_src, pin_dst;
  int   tx0, acc0, w;

  initial begin
    reset = 1'b1; mode_inv = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inbyte = 8'h00;
    mode_inv_8 = 1'b0; in_valid_8 = 1'b0; out_ready_8 = 1'b0; inbyte_8 = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_ready", ready, 0);
    check("rst_outbyte", outbyte, 0);
    check("rst_in_ready_8", in_ready_8, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Pin the model with the literal AES vectors.
    pin_src = '{default: 8'h00};
    for (int i = 0; i < 16; i++) pin_src[i] = A_IN[i];
    xform(pin_src, 1'b1, 4, pin_dst);
    for (int i = 0; i < 16; i++) check("model_inv", pin_dst[i], A_OUT[i]);
    for (int i = 0; i < 16; i++) pin_src[i] = B_IN[i];
    xform(pin_src, 1'b0, 4, pin_dst);
    for (int i = 0; i < 16; i++) check("model_fwd", pin_dst[i], B_OUT[i]);

    // Inverse block, latency, last and ready markers.
    out_ready = 1'b1;
    cap4.delete();
    first_rise_neg = -1;
    for (int i = 0; i < 16; i++) send_byte(A_IN[i], 1'b1);
    wait_drain();
    check("inv_count", cap4.size(), 16);
    for (int i = 0; i < 16 && i < cap4.size(); i++) check("inv_data", cap4[i], A_OUT[i]);
    check("latency", first_rise_neg - last_acc_neg, 1);
    check("last_byte", last_byte, 8'h30);
    check("ready_byte", ready_byte, 8'hd4);

    // Forward block.
    cap4.delete();
    for (int i = 0; i < 16; i++) send_byte(A_OUT[i], 1'b0);
    wait_drain();
    for (int i = 0; i < 16 && i < cap4.size(); i++) check("fwd_data", cap4[i], A_IN[i]);

    // Back-to-back blocks with no gaps on either side.
    cap4.delete();
    stalls = 0;
    first_tx_neg = -1;
    for (int i = 0; i < 16; i++) send_byte(A_IN[i], 1'b1);
    for (int i = 0; i < 16; i++) send_byte(B_IN[i], 1'b0);
    wait_drain();
    check("b2b_stalls", stalls, 0);
    check("b2b_span", last_tx_neg - first_tx_neg, 31);
    check("b2b_count", cap4.size(), 32);
    for (int i = 0; i < 16 && 16 + i < cap4.size(); i++) check("b2b_data", cap4[16+i], B_OUT[i]);

    // Backpressure: three blocks offered while the output is stalled.
    out_ready = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 48; i++) send_byte(8'($urandom), 1'($urandom));
      end
      begin
        repeat (60) @(posedge clock);
        #1;
        check("bp_accepted", acc_cnt - acc0, 32);
        check("bp_in_ready", in_ready, 0);
        tx0 = tx_cnt;
        out_ready = 1'b1;
        w = 0;
        do begin
          @(posedge clock);
          #1;
          w++;
        end while (!in_ready && w < 200);
        check("bp_release_after", tx_cnt - tx0, 16);
      end
    join
    wait_drain();

    // Reset in the middle of a block.
    for (int i = 0; i < 7; i++) send_byte(A_IN[i], 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
    end
    @(posedge clock);
    #1;
    cap4.delete();
    for (int i = 0; i < 16; i++) send_byte(A_IN[i], 1'b1);
    wait_drain();
    check("post_rst_count", cap4.size(), 16);
    for (int i = 0; i < 16 && i < cap4.size(); i++) check("post_rst_data", cap4[i], A_OUT[i]);

    // NB=8 forward on 00..1f.
    out_ready_8 = 1'b1;
    cap8.delete();
    last8.delete();
    for (int i = 0; i < 32; i++) begin
      inbyte_8   = 8'(i);
      mode_inv_8 = 1'b0;
      in_valid_8 = 1'b1;
      @(negedge clock);
      check("nb8_in_ready", in_ready_8, 1);
      @(posedge clock);
      #1;
    end
    in_valid_8 = 1'b0;
    w = 0;
    while (cap8.size() < 32 && w < 200) begin
      @(posedge clock);
      w++;
    end
    #1;
    check("nb8_count", cap8.size(), 32);
    for (int i = 0; i < 32; i++) pin_src[i] = 8'(i);
    xform(pin_src, 1'b0, 8, pin_dst);
    for (int i = 0; i < 32 && i < cap8.size(); i++) check("nb8_data", cap8[i], pin_dst[i]);
    for (int i = 0; i < 4 && i < cap8.size(); i++) check("nb8_col0", cap8[i], COL0_8[i]);
    if (cap8.size() == 32) begin
      check("nb8_last", last8[31], 1);
      check("nb8_not_last", last8[0], 0);
    end

    // Random blocks, random per-byte mode, random gaps and backpressure.
    rand_bp = 1'b1;
    for (int blk = 0; blk < 30; blk++) begin
      for (int i = 0; i < 16; i++) begin
        send_byte(8'($urandom), 1'($urandom));
        if ($urandom_range(0, 5) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clock);
          #1;
        end
      end
    end
    rand_bp = 1'b0;
    @(posedge clock);
    #2;
    out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
